// File: rtl/delay_timer_arbiter.sv
// delay_timer_arbiter: round-robin sharing of one delay counter among NREQ requesters
module delay_timer_arbiter #(
  parameter int NREQ = 4,
  parameter int SIZE = 8
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*SIZE-1:0] req_delay,
  output logic [NREQ-1:0]      grant,
  output logic [NREQ-1:0]      done,
  output logic                 busy,
  output logic [SIZE-1:0]      count
);
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  typedef enum logic [1:0] {IDLE, COUNT, DONE} state_t;
  state_t state, state_n;
  logic [IW-1:0] idx, idx_n, ptr, ptr_n, sel, idx_inc;
  logic [SIZE-1:0] dly, dly_n, count_n, count_inc;
  logic [SIZE-1:0] dl [NREQ];
  logic found;
  for (genvar g = 0; g < NREQ; g++) begin : g_slice
    assign dl[g] = req_delay[g*SIZE +: SIZE];
  end
  // scan from farthest to nearest offset so the nearest set bit at/after ptr wins
  always_comb begin
    sel = '0;
    found = 1'b0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req[IW'((int'(ptr) + i) % NREQ)]) begin
        found = 1'b1;
        sel = IW'((int'(ptr) + i) % NREQ);
      end
    end
  end
  assign idx_inc   = (idx == IW'(NREQ - 1)) ? '0 : idx + 1'b1;
  assign count_inc = count + 1'b1;
  always_comb begin
    state_n = state;
    idx_n   = idx;
    dly_n   = dly;
    ptr_n   = ptr;
    count_n = count;
    case (state)
      IDLE: if (found) begin
        state_n = COUNT;
        idx_n   = sel;
        dly_n   = (dl[sel] == '0) ? SIZE'(1) : dl[sel];
        count_n = '0;
      end
      COUNT: if (!req[idx]) begin
        state_n = IDLE;
        ptr_n   = idx_inc;
        count_n = '0;
      end else begin
        count_n = count_inc;
        state_n = (count_inc == dly) ? DONE : COUNT;
      end
      default: begin
        state_n = IDLE;
        ptr_n   = idx_inc;
        count_n = '0;
      end
    endcase
  end
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state <= IDLE;
      idx   <= '0;
      dly   <= '0;
      ptr   <= '0;
      count <= '0;
    end else begin
      state <= state_n;
      idx   <= idx_n;
      dly   <= dly_n;
      ptr   <= ptr_n;
      count <= count_n;
    end
  end
  always_comb begin
    grant = '0;
    done  = '0;
    if (state != IDLE) grant[idx] = 1'b1;
    if (state == DONE) done[idx] = 1'b1;
  end
  assign busy = (state != IDLE);
endmodule

// File: tb/tb_delay_timer_arbiter.sv
// tb_delay_timer_arbiter: directed vectors plus randomized run against a service-window model
module tb_delay_timer_arbiter;
  logic        clk = 1'b0;
  logic        n_rst = 1'b0;
  logic [3:0]  req = '0;
  logic [31:0] req_delay = '0;
  logic [3:0]  grant, done;
  logic        busy;
  logic [7:0]  count;

  delay_timer_arbiter #(.NREQ(4), .SIZE(8)) dut (
    .clk(clk), .n_rst(n_rst), .req(req), .req_delay(req_delay),
    .grant(grant), .done(done), .busy(busy), .count(count)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0, cyc = 0;
  // model: a service is a window of cycles [m_start, m_start+m_deff], done on the last one
  bit m_busy = 0;
  int m_idx = 0, m_start = 0, m_deff = 0, m_ptr = 0;

  typedef struct {
    logic [3:0]  r;
    logic [31:0] d;
    int          gidx;
    int          deff;
  } vec_t;
  vec_t vecs[5];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic model_check();
    logic [3:0] g;
    int k;
    k = cyc - m_start;
    g = m_busy ? 4'(1 << m_idx) : 4'd0;
    chk("m_grant", 32'(grant), 32'(g));
    chk("m_done", 32'(done), (m_busy && k == m_deff) ? 32'(g) : 32'd0);
    chk("m_busy", 32'(busy), 32'(m_busy));
    chk("m_count", 32'(count), m_busy ? k : 0);
  endtask

  task automatic tick(input logic [3:0] r, input logic [31:0] d);
    bit found;
    int dv, k, j;
    req = r;
    req_delay = d;
    if (!m_busy) begin
      if (r != 0) begin
        found = 0;
        for (int i = 0; i < 4; i++) begin
          j = (m_ptr + i) % 4;
          if (!found && r[j]) begin
            found = 1;
            m_idx = j;
          end
        end
        dv = int'((d >> (8 * m_idx)) & 32'hFF);
        m_deff = (dv == 0) ? 1 : dv;
        m_start = cyc + 1;
        m_busy = 1;
      end
    end else begin
      k = cyc - m_start;
      if (k == m_deff || !r[m_idx]) begin
        m_busy = 0;
        m_ptr = (m_idx + 1) % 4;
      end
    end
    @(negedge clk);
    cyc++;
    model_check();
  endtask

  task automatic check_zero(input string name);
    chk({name, "_grant"}, 32'(grant), 0);
    chk({name, "_done"}, 32'(done), 0);
    chk({name, "_busy"}, 32'(busy), 0);
    chk({name, "_count"}, 32'(count), 0);
  endtask

  task automatic do_reset();
    req = '0;
    n_rst = 1'b0;
    #1;
    check_zero("reset");
    m_busy = 0;
    m_ptr = 0;
    @(negedge clk);
    n_rst = 1'b1;
    cyc = 0;
  endtask

  initial begin
    logic [3:0]  r, g;
    logic [31:0] d;
    int b;
    vecs[0] = '{4'b0001, 32'h0000_0005, 0, 5};
    vecs[1] = '{4'b0100, 32'h0000_0000, 2, 1};
    vecs[2] = '{4'b1000, 32'hFF00_0000, 3, 255};
    vecs[3] = '{4'b0110, 32'h0000_0300, 1, 3};
    vecs[4] = '{4'b1010, 32'h0700_0100, 1, 1};
    foreach (vecs[v]) begin
      do_reset();
      for (int c = 1; c <= vecs[v].deff + 1; c++) begin
        tick(vecs[v].r, vecs[v].d);
        chk("tbl_grant", 32'(grant), 32'(1 << vecs[v].gidx));
        chk("tbl_done", 32'(done), (c == vecs[v].deff + 1) ? 32'(1 << vecs[v].gidx) : 0);
        chk("tbl_count", 32'(count), c - 1);
      end
      tick(4'b0000, vecs[v].d);
      chk("tbl_release", 32'(grant), 0);
    end
    // round robin with 1-cycle bubble after each done
    do_reset();
    for (int c = 1; c <= 20; c++) begin
      tick(4'hF, 32'h0202_0202);
      g = ((c - 1) % 4 == 3) ? 4'd0 : 4'(1 << (((c - 1) / 4) % 4));
      chk("rr_grant", 32'(grant), 32'(g));
      chk("rr_done", 32'(done), ((c - 1) % 4 == 2) ? 32'(g) : 0);
    end
    // abort: drop req[1] during cycle 4
    do_reset();
    for (int c = 1; c <= 4; c++) begin
      tick(4'b0010, 32'h0000_0A00);
      chk("abort_grant", 32'(grant), 32'h2);
      chk("abort_done", 32'(done), 0);
    end
    tick(4'b0000, 32'h0000_0A00);
    chk("abort_release", 32'(grant), 0);
    chk("abort_nodone", 32'(done), 0);
    tick(4'b0011, 32'h0000_0A01);
    chk("abort_next", 32'(grant), 32'h1);
    // delay change after latching is ignored
    do_reset();
    tick(4'b0001, 32'h3);
    chk("latch_grant", 32'(grant), 32'h1);
    for (int c = 2; c <= 5; c++) begin
      tick(4'b0001, 32'h9);
      chk("latch_done", 32'(done), (c == 4) ? 32'h1 : 0);
      chk("latch_grant", 32'(grant), (c <= 4) ? 32'h1 : 0);
    end
    // async reset mid-count
    do_reset();
    for (int c = 1; c <= 4; c++) tick(4'b0001, 32'd10);
    chk("ar_count3", 32'(count), 3);
    #2;
    n_rst = 1'b0;
    #1;
    check_zero("async");
    m_busy = 0;
    m_ptr = 0;
    @(negedge clk);
    n_rst = 1'b1;
    cyc = 0;
    for (int c = 1; c <= 3; c++) begin
      tick(4'b0001, 32'd2);
      chk("ar_grant", 32'(grant), 32'h1);
      chk("ar_done", 32'(done), (c == 3) ? 32'h1 : 0);
    end
    tick(4'b0000, 32'd2);
    chk("ar_release", 32'(grant), 0);
    // randomized run against the model
    do_reset();
    r = '0;
    d = 32'h0302_0100;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 5) == 0) begin
        b = int'($urandom_range(0, 3));
        r[b] = ~r[b];
      end
      if ($urandom_range(0, 19) == 0)
        for (int i = 0; i < 4; i++) d[i*8 +: 8] = 8'($urandom_range(0, 6));
      tick(r, d);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/delay_timer_arbiter.md
# delay_timer_arbiter

Shares one SIZE-bit delay counter among NREQ requesters. Each requester asks for a wait of D clock cycles. The block picks one requester round-robin, latches its delay, counts it out, and returns a one-cycle done pulse to that requester. It sits between the pipeline/peripheral blocks that need timed waits and the single shared counter resource, so individual requesters do not each need their own counter.

## Interface
- NREQ, 4, number of requesters (2..8)
- SIZE, 8, counter and delay width in bits
- clk  in  1  clock, all state changes on rising edge
- n_rst  in  1  reset, asynchronous, active-low
- req  in  NREQ  level request per requester, held until done or abort
- req_delay  in  NREQ*SIZE  delay per requester; requester i uses bits [i*SIZE +: SIZE]
- grant  out  NREQ  one-hot, requester currently owning the counter
- done  out  NREQ  one-cycle pulse to requester whose delay expired
- busy  out  1  high while any grant is asserted
- count  out  SIZE  current counter value (debug/visibility)

## Operation
- Reset values: grant=0, done=0, busy=0, count=0, state=IDLE, rr pointer=0 (requester 0 highest priority), latched index/delay=0.
- States: IDLE, COUNT, DONE.
- IDLE: if any req bit set, select the first set bit at or after the pointer, wrapping modulo NREQ. Latch its index and req_delay slice, clear count to 0, go to COUNT. With no req, stay IDLE with outputs 0.
- Effective delay: D_eff = max(D, 1). D=0 is treated as 1.
- COUNT: grant[idx]=1, busy=1, count increments by 1 each cycle. When count+1 == D_eff, go to DONE, with count holding D_eff in the DONE cycle.
- DONE: done[idx]=1 for exactly this cycle, grant[idx] still 1. Next state is IDLE. Pointer = (idx+1) mod NREQ. count clears to 0.
- Abort: if req[idx] is 0 in any COUNT cycle, go to IDLE next cycle with no done pulse. Pointer = (idx+1) mod NREQ, count clears to 0.
- req_delay changes after latching are ignored for the current service. Changes to other requesters' req bits during service do not affect the current service.
- A requester still asserting req after its done pulse is eligible again, but only after the pointer has rotated past it.
- Arithmetic: count is SIZE bits and never exceeds D_eff ≤ 2^SIZE−1, so there is no wrap inside a service.
- Exactly one grant bit is high at any time outside IDLE. done is only ever asserted together with the matching grant bit.

## Timing
- Arbitration cycle t (IDLE, req seen) → grant/busy high from t+1.
- Done pulse occurs D_eff cycles after grant rises: grant at t+1, done at t+1+D_eff. grant falls at t+2+D_eff.
- Back-to-back: a done at cycle T is followed by IDLE at T+1 and the next grant at T+2. This gives a 1-cycle arbitration bubble.
- Abort: req[idx] low at cycle a → grant low at a+1, with arbitration in that same IDLE cycle.
- Reset asserted mid-service: all outputs go to 0 immediately (asynchronously). After release the block is in IDLE with pointer 0, and no done is issued for the interrupted service.
- Outputs are registered or decoded from state only. There is no combinational path from req to grant or done.

## Test plan
- Single request: req=0001, delay0=5 → grant=0001 from cycle 1, count 1..4 in COUNT, done[0] pulse at cycle 6, grant=0 at cycle 7.
- Zero delay: req=0100, delay2=0 → grant=0100 at cycle 1, done[2] at cycle 2 (behaves as D=1).
- Round-robin: req=1111 held, all delays=2 → grants in order 0,1,2,3,0. Each done is followed by a 1-cycle idle before the next grant.
- Abort: req=0010, delay1=10; drop req[1] at cycle 4 → grant=0 at cycle 5, no done pulse, pointer=2. A following req=0011 grants requester 0 only after requester 1 is skipped per the pointer (i.e., the grant order respects pointer=2, wrapping to 0).
- Delay latching: change delay0 from 3 to 9 one cycle after grant → done still arrives at grant+3.
- Async reset mid-COUNT (count=3) → grant/busy/count/done are 0 without a clock edge. After release with req=0001, delay0=2, service restarts normally and done arrives at grant+2.
